// File: rtl/serial_fsm_arb.sv
// Two-requester arbiter that resets a shared bit-serial Moore FSM, shifts a word into it LSB-first and reports its output.
// Define SFA_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); the default is round-robin.
module serial_fsm_arb #(
  parameter int WORD_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [WORD_W-1:0] word0_i,
  input  logic [WORD_W-1:0] word1_i,
  input  logic [LEN_W-1:0]  len0_i,
  input  logic [LEN_W-1:0]  len1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              done_id_o,
  output logic [1:0]        result_o,
  output logic [LEN_W-1:0]  hits_o,
  output logic              fsm_x_o,
  output logic              fsm_rst_n_o,
  input  logic [1:0]        fsm_y_i
);
  typedef enum logic [2:0] {IDLE, RST, SHIFT, CAPT, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORD_W);

  state_t            state, state_nx;
  logic [WORD_W-1:0] word_q;
  logic [LEN_W-1:0]  len_q, idx_q, hit_cnt, hits_q;
  logic [1:0]        result_q;
  logic              owner_q;
  logic              any_req, pick;
  logic [LEN_W-1:0]  len0_c, len1_c;

  assign any_req = req0_i | req1_i;
  assign len0_c  = (len0_i > MAX_LEN) ? MAX_LEN : len0_i;
  assign len1_c  = (len1_i > MAX_LEN) ? MAX_LEN : len1_i;

`ifdef SFA_FIXED_PRIO_EN
  assign pick = ~req0_i;
`else
  // last_q names the requester granted most recently; the other one wins a tie.
  logic last_q;
  assign pick = (req0_i & req1_i) ? ~last_q : ~req0_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_q <= pick;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      word_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      hit_cnt  <= '0;
      hits_q   <= '0;
      result_q <= '0;
      owner_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= pick;
            word_q  <= pick ? word1_i : word0_i;
            len_q   <= pick ? len1_c : len0_c;
            idx_q   <= '0;
            hit_cnt <= '0;
          end
        end
        SHIFT: begin
          // The first SHIFT cycle still shows the post-reset output, so it is not sampled.
          word_q <= word_q >> 1;
          idx_q  <= idx_q + LEN_W'(1);
          if (idx_q != '0 && fsm_y_i == 2'b11) begin
            hit_cnt <= hit_cnt + LEN_W'(1);
          end
        end
        CAPT: begin
          result_q <= fsm_y_i;
          hits_q   <= hit_cnt + ((len_q != '0 && fsm_y_i == 2'b11) ? LEN_W'(1) : LEN_W'(0));
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    done_id_o   = 1'b0;
    fsm_x_o     = 1'b0;
    fsm_rst_n_o = 1'b1;
    result_o    = result_q;
    hits_o      = hits_q;
    case (state)
      IDLE: begin
        if (any_req) state_nx = RST;
      end
      RST: begin
        busy_o      = 1'b1;
        gnt0_o      = ~owner_q;
        gnt1_o      = owner_q;
        fsm_rst_n_o = 1'b0;
        state_nx    = (len_q == '0) ? CAPT : SHIFT;
      end
      SHIFT: begin
        busy_o  = 1'b1;
        fsm_x_o = word_q[0];
        if (idx_q == len_q - LEN_W'(1)) state_nx = CAPT;
      end
      CAPT: begin
        busy_o   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        done_id_o = owner_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset forces every output low, including the downstream FSM reset.
    if (rst_i) begin
      gnt0_o      = 1'b0;
      gnt1_o      = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      done_id_o   = 1'b0;
      fsm_x_o     = 1'b0;
      fsm_rst_n_o = 1'b0;
      result_o    = '0;
      hits_o      = '0;
    end
  end
endmodule

// File: tb/tb_serial_fsm_arb.sv
// Bench for serial_fsm_arb: directed jobs, a grant/done scoreboard checked by a negedge monitor,
// and a reference FSM whose output counts received 1 bits mod 4.
module tb_serial_fsm_arb;
  localparam int WORD_W = 8;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [WORD_W-1:0] word0 = '0, word1 = '0;
  logic [LEN_W-1:0]  len0 = '0, len1 = '0;
  logic              gnt0_o, gnt1_o, busy_o, done_o, done_id_o, fsm_x_o, fsm_rst_n_o;
  logic [1:0]        result_o;
  logic [LEN_W-1:0]  hits_o;
  logic [1:0]        fsm_y;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {done_id, result, hits} for completions, requester id for grants.
  logic [6:0] exp_q[$];
  logic       gnt_q[$];

  always #5 clk = ~clk;

  serial_fsm_arb #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .word0_i(word0), .word1_i(word1),
    .len0_i(len0), .len1_i(len1),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o),
    .result_o(result_o), .hits_o(hits_o),
    .fsm_x_o(fsm_x_o), .fsm_rst_n_o(fsm_rst_n_o), .fsm_y_i(fsm_y)
  );

  always @(posedge clk) begin
    if (!fsm_rst_n_o) fsm_y <= 2'd0;
    else if (fsm_x_o) fsm_y <= fsm_y + 2'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done_o) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'(done_o), 32'd0);
      else chk("done_payload", 32'({done_id_o, result_o, hits_o}), 32'(exp_q.pop_front()));
    end
    if (gnt0_o || gnt1_o) begin
      if (gnt_q.size() == 0) chk("unexpected_gnt", 32'({gnt1_o, gnt0_o}), 32'd0);
      else chk("gnt_id", 32'({gnt1_o, gnt0_o}), gnt_q.pop_front() ? 32'd2 : 32'd1);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({gnt0_o, gnt1_o, busy_o, done_o, done_id_o, result_o, hits_o,
                            fsm_x_o, fsm_rst_n_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 32'({busy_o, fsm_rst_n_o, fsm_x_o}), 32'b010);
  endtask

  // One requester alone; checks grant cycle, serial bit stream and done latency from the request edge.
  task automatic single_job(input logic id, input logic [7:0] w, input logic [3:0] l,
                            input logic [1:0] er, input logic [3:0] eh,
                            input logic [7:0] ex_x, input int elen);
    logic [7:0] xs;
    int done_at;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; word1 = w; len1 = l; end
    else begin req0 = 1'b1; word0 = w; len0 = l; end
    exp_q.push_back({id, er, eh});
    gnt_q.push_back(id);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    xs = '0;
    done_at = -1;
    for (int c = 1; c <= elen + 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("gnt_cycle", 32'({gnt1_o, gnt0_o, fsm_rst_n_o}), id ? 32'b100 : 32'b010);
      if (c >= 2 && c <= elen + 1) xs[c-2] = fsm_x_o;
      if (done_o && done_at < 0) done_at = c;
    end
    chk("x_seq", 32'(xs), 32'(ex_x));
    chk("done_latency", 32'(done_at), 32'(elen + 3));
  endtask

  initial begin
    int dones;
    int seen;
    do_reset();

    single_job(1'b0, 8'b0000_1011, 4'd4,  2'd3, 4'd1, 8'h0B, 4);
    single_job(1'b1, 8'hFF,        4'd15, 2'd0, 4'd2, 8'hFF, 8);
    single_job(1'b0, 8'hA5,        4'd0,  2'd0, 4'd0, 8'h00, 0);
    single_job(1'b1, 8'h07,        4'd3,  2'd3, 4'd1, 8'h07, 3);
    single_job(1'b1, 8'hFF,        4'd7,  2'd3, 4'd2, 8'h7F, 7);
    single_job(1'b0, 8'b1111_0110, 4'd6,  2'd0, 4'd1, 8'h36, 6);

    // Continuous tie; last grant above was requester 0, so a reset pointer must pick 0 first.
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef SFA_FIXED_PRIO_EN
      gnt_q.push_back(1'b0);
      exp_q.push_back({1'b0, 2'd2, 4'd0});
`else
      gnt_q.push_back(i[0]);
      exp_q.push_back(i[0] ? {1'b1, 2'd1, 4'd0} : {1'b0, 2'd2, 4'd0});
`endif
    end
    @(posedge clk); #1;
    word0 = 8'h03; len0 = 4'd2; word1 = 8'h01; len1 = 4'd2;
    req0 = 1'b1; req1 = 1'b1;
    dones = 0;
    for (int c = 0; c < 60 && dones < 4; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_done_count", 32'(dones), 32'd4);
    repeat (3) @(negedge clk);
    chk("tie_drained", 32'(busy_o), 32'd0);

    // Reset in the third SHIFT cycle of a requester-0 job while requester 1 waits.
    do_reset();
    gnt_q.push_back(1'b0);
    @(posedge clk); #1;
    req0 = 1'b1; word0 = 8'hFF; len0 = 4'd8;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b1; word1 = 8'h0F; len1 = 4'd4;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midjob_rst_outputs", 32'({gnt0_o, gnt1_o, busy_o, done_o, done_id_o, result_o, hits_o,
                                   fsm_x_o, fsm_rst_n_o}), 32'd0);
    gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 2'd0, 4'd1});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midjob_idle", 32'({busy_o, fsm_rst_n_o, done_o}), 32'b010);
    seen = 0;
    for (int c = 0; c < 5 && seen == 0; c++) begin
      @(negedge clk);
      if (gnt1_o) seen = 1;
    end
    req1 = 1'b0;
    chk("midjob_gnt1_seen", 32'(seen), 32'd1);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    chk("midjob_done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
